// File: rtl/lenet_fp16_pkg.sv
// Shared FP16 definitions for the LeNet inference blocks: field widths,
// special encodings, the argmax FSM state type and a NaN predicate.
package lenet_fp16_pkg;

  localparam int FP16_W      = 16;
  localparam int FP16_EXP_W  = 5;
  localparam int FP16_MANT_W = 10;

  localparam logic [FP16_W-1:0]     FP16_POS_ZERO = 16'h0000;
  localparam logic [FP16_W-1:0]     FP16_NEG_ZERO = 16'h8000;
  localparam logic [FP16_EXP_W-1:0] FP16_EXP_MAX  = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } argmax_state_t;

  function automatic logic fp16_is_nan(input logic [FP16_W-1:0] x);
    return (x[FP16_W-2 -: FP16_EXP_W] == FP16_EXP_MAX) &&
           (x[FP16_MANT_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/fc_argmax_float16_greater.sv
// Combinational FP16 "strictly greater" compare with NaN handling; a NaN
// never wins, any ordered value beats a NaN, and the two zeros compare equal.
module Float16Greater
  import lenet_fp16_pkg::*;
(
  input  logic [FP16_W-1:0] a,
  input  logic [FP16_W-1:0] b,
  output logic              a_gt_b,
  output logic              a_is_nan
);

  logic              w_b_is_nan;
  logic [FP16_W-1:0] w_key_a;
  logic [FP16_W-1:0] w_key_b;

  // Maps sign-magnitude FP16 onto an unsigned key with the same ordering.
  function automatic logic [FP16_W-1:0] order_key(input logic [FP16_W-1:0] x);
    logic [FP16_W-1:0] v;
    v = (x == FP16_NEG_ZERO) ? FP16_POS_ZERO : x;
    return v[FP16_W-1] ? {1'b0, ~v[FP16_W-2:0]} : {1'b1, v[FP16_W-2:0]};
  endfunction

  assign a_is_nan   = fp16_is_nan(a);
  assign w_b_is_nan = fp16_is_nan(b);
  assign w_key_a    = order_key(a);
  assign w_key_b    = order_key(b);
  assign a_gt_b     = !a_is_nan && (w_b_is_nan || (w_key_a > w_key_b));

endmodule

// File: rtl/fc_argmax.sv
// Sequential argmax over the FC output logits: snapshots the vector on start,
// compares one channel per clock, and reports the winning class and value.
module fc_argmax
  import lenet_fp16_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int output_channel = 10,
  parameter int IDX_W          = (output_channel > 1) ? $clog2(output_channel) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [output_channel*DATA_WIDTH-1:0] logits,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic [IDX_W-1:0]                     class_idx,
  output logic [DATA_WIDTH-1:0]                max_value,
  output logic                                 all_nan
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(output_channel - 1);

  argmax_state_t         r_state;
  argmax_state_t         w_next_state;
  logic [DATA_WIDTH-1:0] r_snap [output_channel];
  logic [IDX_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_best;
  logic [IDX_W-1:0]      r_best_idx;
  logic                  r_all_nan;
  logic [IDX_W-1:0]      r_class_idx;
  logic [DATA_WIDTH-1:0] r_max_value;
  logic                  r_out_nan;

  logic [DATA_WIDTH-1:0] w_cand;
  logic                  w_cand_wins;
  logic                  w_cand_nan;
  logic [DATA_WIDTH-1:0] w_upd_best;
  logic [IDX_W-1:0]      w_upd_idx;
  logic                  w_upd_nan;

  assign w_cand = r_snap[r_cnt];

  Float16Greater u_cmp (
    .a        (w_cand),
    .b        (r_best),
    .a_gt_b   (w_cand_wins),
    .a_is_nan (w_cand_nan)
  );

  // best stays NaN only while every channel seen so far is NaN
  assign w_upd_best = w_cand_wins ? w_cand : r_best;
  assign w_upd_idx  = w_cand_wins ? r_cnt  : r_best_idx;
  assign w_upd_nan  = r_all_nan & w_cand_nan;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_next_state = (output_channel == 1) ? ST_DONE : ST_SCAN;
      ST_SCAN: begin
        busy = 1'b1;
        if (r_cnt == LAST_IDX) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: the snapshot is a handful of flops, not a RAM, so it is cleared on
  // reset like the rest of the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < output_channel; i++) r_snap[i] <= '0;
      r_cnt       <= '0;
      r_best      <= '0;
      r_best_idx  <= '0;
      r_all_nan   <= 1'b0;
      r_class_idx <= '0;
      r_max_value <= '0;
      r_out_nan   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          for (int i = 0; i < output_channel; i++)
            r_snap[i] <= logits[i*DATA_WIDTH +: DATA_WIDTH];
          r_cnt      <= IDX_W'(1);
          r_best     <= logits[DATA_WIDTH-1:0];
          r_best_idx <= '0;
          r_all_nan  <= fp16_is_nan(logits[DATA_WIDTH-1:0]);
          if (output_channel == 1) begin
            r_class_idx <= '0;
            r_max_value <= logits[DATA_WIDTH-1:0];
            r_out_nan   <= fp16_is_nan(logits[DATA_WIDTH-1:0]);
          end
        end
        ST_SCAN: begin
          r_best     <= w_upd_best;
          r_best_idx <= w_upd_idx;
          r_all_nan  <= w_upd_nan;
          r_cnt      <= r_cnt + 1'b1;
          // Results are published on the edge that enters DONE.
          if (r_cnt == LAST_IDX) begin
            r_class_idx <= w_upd_idx;
            r_max_value <= w_upd_best;
            r_out_nan   <= w_upd_nan;
          end
        end
        default: ;
      endcase
    end
  end

  assign class_idx = r_class_idx;
  assign max_value = r_max_value;
  assign all_nan   = r_out_nan;

endmodule

// File: tb/tb_fc_argmax.sv
// Self-checking bench for fc_argmax: table of logit vectors with hand-derived
// results, scoreboarded against done, plus disturb and mid-scan reset cases.
module tb_fc_argmax;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int LW = N * DW;
  localparam int IW = 4;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] val;
    logic          nan;
  } exp_t;

  typedef struct {
    logic [LW-1:0] lg;
    exp_t          e;
    string         name;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [LW-1:0] logits;
  logic          start;
  logic          busy;
  logic          done;
  logic [IW-1:0] class_idx;
  logic [DW-1:0] max_value;
  logic          all_nan;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  vec_t vecs[9];

  fc_argmax #(.DATA_WIDTH(DW), .output_channel(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .logits    (logits),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .class_idx (class_idx),
    .max_value (max_value),
    .all_nan   (all_nan)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] put(input logic [LW-1:0] v, input int ch, input logic [DW-1:0] x);
    logic [LW-1:0] r;
    r = v;
    r[ch*DW +: DW] = x;
    return r;
  endfunction

  function automatic logic [LW-1:0] rand_logits();
    logic [LW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'($urandom_range(0, 16'hFFFF));
    return r;
  endfunction

  // One scan: pulse start, wait for done, compare latency, busy width and results.
  task automatic run_scan(input logic [LW-1:0] lg, input exp_t e, input string name, input bit disturb);
    int   n;
    int   busy_n;
    int   extra;
    exp_t got;
    @(negedge clk);
    logits = lg;
    start  = 1'b1;
    exp_q.push_back(e);
    n      = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      n++;
      start = disturb && (n == 4);
      if (disturb) logits = rand_logits();
      if (busy) busy_n++;
    end while (!done && n < 40);
    check({name, "_latency"}, n, N);
    check({name, "_busy_cycles"}, busy_n, N - 1);
    check({name, "_sb_size"}, exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      got = exp_q.pop_front();
      check({name, "_class_idx"}, class_idx, got.idx);
      check({name, "_max_value"}, max_value, got.val);
      check({name, "_all_nan"}, all_nan, got.nan);
    end
    @(negedge clk);
    check({name, "_done_pulse"}, done, 1'b0);
    if (disturb) begin
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done) extra++;
      end
      check({name, "_extra_done"}, extra, 0);
    end
  endtask

  initial begin
    logic [LW-1:0] v;
    int            n;
    int            dn;

    v = {N{16'h3C00}};
    vecs[0] = '{put(v, 3, 16'h4200), '{4'd3, 16'h4200, 1'b0}, "max_ch3"};
    v = {N{16'hC200}};
    v = put(put(put(v, 0, 16'hC000), 7, 16'hBC00), 9, 16'hC400);
    vecs[1] = '{v, '{4'd7, 16'hBC00, 1'b0}, "all_negative"};
    v = {N{16'hBC00}};
    vecs[2] = '{put(put(v, 2, 16'h8000), 5, 16'h0000), '{4'd2, 16'h8000, 1'b0}, "zero_tie"};
    v = {N{16'h0000}};
    vecs[3] = '{put(put(v, 0, 16'h7E00), 4, 16'h7C00), '{4'd4, 16'h7C00, 1'b0}, "nan_inf"};
    vecs[4] = '{{N{16'h7E00}}, '{4'd0, 16'h7E00, 1'b1}, "all_nan"};
    vecs[5] = '{put({N{16'hFC00}}, 9, 16'hFBFF), '{4'd9, 16'hFBFF, 1'b0}, "last_idx"};
    vecs[6] = '{put({N{16'h7BFF}}, 0, 16'h7C00), '{4'd0, 16'h7C00, 1'b0}, "first_idx_inf"};
    v = put(put(put({N{16'hC000}}, 0, 16'h7C01), 5, 16'hFE00), 8, 16'hBC00);
    vecs[7] = '{v, '{4'd8, 16'hBC00, 1'b0}, "neg_nan"};
    v = put(put({N{16'h8001}}, 1, 16'h0001), 6, 16'h0000);
    vecs[8] = '{v, '{4'd1, 16'h0001, 1'b0}, "denormal"};

    reset  = 1'b1;
    start  = 1'b0;
    logits = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_class_idx", class_idx, 0);
    check("rst_max_value", max_value, 16'h0000);
    check("rst_all_nan", all_nan, 1'b0);
    reset = 1'b0;

    // Back-to-back table scans; each new start lands in the cycle after done's check.
    for (int i = 0; i < 9; i++) run_scan(vecs[i].lg, vecs[i].e, vecs[i].name, 1'b0);

    // Inputs churn every cycle and start is pulsed mid-scan.
    run_scan(vecs[0].lg, vecs[0].e, "disturb", 1'b1);

    // Reset four cycles into a scan aborts it asynchronously.
    @(negedge clk);
    logits = vecs[1].lg;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_class_idx", class_idx, 0);
    check("abort_max_value", max_value, 16'h0000);
    check("abort_all_nan", all_nan, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    for (n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check("abort_no_activity", dn, 0);
    run_scan(vecs[1].lg, vecs[1].e, "after_abort", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
